// File: rtl/mem_port_arbiter_if.sv
// Shared-memory port bundle between the IF/MEM stages, the arbiter and the memory bank.
// The master view belongs to the arbiter; the slave view belongs to its surroundings.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport master (
    input  i_req, i_addr, i_flush,
    output i_done, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_done, d_rdata,
    output m_req, m_we, m_addr, m_wdata,
    input  m_ack, m_rdata,
    output stall_if, stall_mem
  );

  modport slave (
    output i_req, i_addr, i_flush,
    input  i_done, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_done, d_rdata,
    input  m_req, m_we, m_addr, m_wdata,
    output m_ack, m_rdata,
    input  stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one req/ack memory port.
// Data has priority until a waiting fetch has been passed over STARVE_MAX times.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.master bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RESP
  } state_t;

  state_t        state;
  state_t        nextState;
  logic [CW-1:0] starveCnt;
  logic          flushPend;
  logic          starved;
  logic          grantI;
  logic          grantD;
  logic          fetchAck;
  logic          dataAck;
  logic          keepFetch;

  assign starved   = bus.i_req && (starveCnt == CW'(STARVE_MAX));
  assign fetchAck  = (state == GNT_I) && bus.m_ack;
  assign dataAck   = (state == GNT_D) && bus.m_ack;
  assign keepFetch = fetchAck && !flushPend && !bus.i_flush;

  assign bus.stall_if  = bus.i_req & ~bus.i_done;
  assign bus.stall_mem = bus.d_req & ~bus.d_done;

  always_comb begin
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.d_req && !starved) begin
          nextState = GNT_D;
          grantD    = 1'b1;
        end else if (bus.i_req && !bus.i_flush) begin
          nextState = GNT_I;
          grantI    = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (bus.m_ack) nextState = RESP;
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.i_done  <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      bus.i_done <= keepFetch;
      bus.d_done <= dataAck;
      if (grantD) begin
        bus.m_req   <= 1'b1;
        bus.m_we    <= bus.d_we;
        bus.m_addr  <= bus.d_addr;
        bus.m_wdata <= bus.d_wdata;
      end else if (grantI) begin
        bus.m_req   <= 1'b1;
        bus.m_we    <= 1'b0;
        bus.m_addr  <= bus.i_addr;
        bus.m_wdata <= '0;
      end else if (fetchAck || dataAck) begin
        bus.m_req <= 1'b0;
        bus.m_we  <= 1'b0;
      end
      if (keepFetch) bus.i_rdata <= bus.m_rdata;
      if (dataAck && !bus.m_we) bus.d_rdata <= bus.m_rdata;
    end
  end

  // A flushed fetch still completes on the bus; only its result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flushPend <= 1'b0;
      starveCnt <= '0;
    end else begin
      if (state == RESP) flushPend <= 1'b0;
      else if ((state == GNT_I) && bus.i_flush) flushPend <= 1'b1;
      if (!bus.i_req || grantI) starveCnt <= '0;
      else if (grantD && !starved) starveCnt <= starveCnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level model,
// with directed fetch, store, contention, flush, reset and starvation cases.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          active;
    bit          isData;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          dropped;
  } txn_t;

  txn_t        cur;
  bit          inResp;
  bit          eIDone;
  bit          eDDone;
  logic [31:0] eIRdata;
  logic [31:0] eDRdata;
  int          starve;
  int          ackWait;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memRd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void modelReset();
    cur     = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    inResp  = 1'b0;
    eIDone  = 1'b0;
    eDDone  = 1'b0;
    eIRdata = 32'h0;
    eDRdata = 32'h0;
    starve  = 0;
    ackWait = 0;
  endfunction

  // One clock of the arbiter seen as transactions: grant, bus access, response.
  function automatic void modelStep();
    bit nI = 1'b0;
    bit nD = 1'b0;
    if (inResp) begin
      inResp = 1'b0;
    end else if (cur.active) begin
      if (!cur.isData && bus.i_flush) cur.dropped = 1'b1;
      if (bus.m_ack) begin
        if (cur.isData) begin
          nD = 1'b1;
          if (cur.we) mem[cur.addr] = cur.wdata;
          else eDRdata = memRd(cur.addr);
        end else if (!cur.dropped) begin
          nI = 1'b1;
          eIRdata = memRd(cur.addr);
        end
        cur.active = 1'b0;
        inResp = 1'b1;
      end
    end else if (bus.d_req && !(bus.i_req && starve == SMAX)) begin
      cur = '{1'b1, 1'b1, bus.d_we, bus.d_addr, bus.d_wdata, 1'b0};
      if (bus.i_req && starve < SMAX) starve++;
    end else if (bus.i_req && !bus.i_flush) begin
      cur = '{1'b1, 1'b0, 1'b0, bus.i_addr, 32'h0, 1'b0};
      starve = 0;
    end
    if (!bus.i_req) starve = 0;
    eIDone = nI;
    eDDone = nD;
  endfunction

  task automatic checkOut();
    chk("m_req", bus.m_req, cur.active);
    if (cur.active) begin
      chk("m_we", bus.m_we, cur.we);
      chk("m_addr", bus.m_addr, cur.addr);
      if (cur.isData) chk("m_wdata", bus.m_wdata, cur.wdata);
    end
    chk("i_done", bus.i_done, eIDone);
    chk("d_done", bus.d_done, eDDone);
    chk("i_rdata", bus.i_rdata, eIRdata);
    chk("d_rdata", bus.d_rdata, eDRdata);
  endtask

  task automatic tick();
    #1;
    chk("stall_if", bus.stall_if, bus.i_req & ~eIDone);
    chk("stall_mem", bus.stall_mem, bus.d_req & ~eDDone);
    modelStep();
    @(negedge clk);
    checkOut();
  endtask

  task automatic memDrive(bit a);
    bus.m_ack   = a;
    bus.m_rdata = memRd(bus.m_addr);
  endtask

  task automatic setIdle();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.i_flush = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
  endtask

  task automatic newData();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'($urandom_range(0, 1));
    bus.d_addr  = 32'h100 + 32'($urandom_range(0, 15) * 4);
    bus.d_wdata = $urandom;
  endtask

  initial begin
    bit prevReq;
    bit ifSeen;
    int dGrants;
    int pI, pD, pF, pAck;
    bit a;

    setIdle();
    modelReset();
    mem[32'h40]  = 32'h8C01_0004;
    mem[32'h44]  = 32'h0050_0093;
    mem[32'h100] = 32'h1122_3344;
    repeat (2) @(negedge clk);
    chk("rst m_req", bus.m_req, 0);
    chk("rst m_we", bus.m_we, 0);
    chk("rst i_done", bus.i_done, 0);
    chk("rst d_done", bus.d_done, 0);
    chk("rst m_addr", bus.m_addr, 0);
    chk("rst m_wdata", bus.m_wdata, 0);
    rst_n = 1'b1;

    // fetch only: ack on second m_req cycle
    bus.i_req = 1'b1; bus.i_addr = 32'h40; memDrive(0); tick();
    chk("fetch m_req", bus.m_req, 1);
    chk("fetch m_addr", bus.m_addr, 32'h40);
    memDrive(0); tick();
    memDrive(1); tick();
    chk("fetch i_done", bus.i_done, 1);
    chk("fetch i_rdata", bus.i_rdata, 32'h8C01_0004);
    bus.i_req = 1'b0; memDrive(0); tick();
    chk("fetch done pulse", bus.i_done, 0);

    // store
    bus.d_req = 1'b1; bus.d_we = 1'b1;
    bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF;
    memDrive(0); tick();
    chk("store m_we", bus.m_we, 1);
    chk("store m_addr", bus.m_addr, 32'h200);
    chk("store m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    memDrive(1); tick();
    chk("store d_done", bus.d_done, 1);
    chk("store d_rdata", bus.d_rdata, 0);
    bus.d_req = 1'b0; bus.d_we = 1'b0; memDrive(0); tick();

    // contention: load wins, fetch follows
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_addr = 32'h100;
    memDrive(0); tick();
    chk("cont first addr", bus.m_addr, 32'h100);
    chk("cont stall_if", bus.stall_if, 1);
    memDrive(1); tick();
    chk("cont d_rdata", bus.d_rdata, 32'h1122_3344);
    bus.d_req = 1'b0; memDrive(0); tick();
    chk("cont stall_if wait", bus.stall_if, 1);
    memDrive(0); tick();
    chk("cont second addr", bus.m_addr, 32'h44);
    memDrive(1); tick();
    chk("cont i_done", bus.i_done, 1);
    chk("cont i_rdata", bus.i_rdata, 32'h0050_0093);
    bus.i_req = 1'b0; memDrive(0); tick();

    // flush during GNT_I
    bus.i_req = 1'b1; bus.i_addr = 32'h80; memDrive(0); tick();
    bus.i_flush = 1'b1; bus.i_addr = 32'hC0; memDrive(0); tick();
    chk("flush m_req held", bus.m_req, 1);
    bus.i_flush = 1'b0; memDrive(1); tick();
    chk("flush no i_done", bus.i_done, 0);
    chk("flush i_rdata kept", bus.i_rdata, 32'h0050_0093);
    memDrive(0); tick();
    memDrive(0); tick();
    chk("flush new pc", bus.m_addr, 32'hC0);
    memDrive(1); tick();
    chk("flush new i_done", bus.i_done, 1);
    bus.i_req = 1'b0; memDrive(0); tick();

    // reset in the middle of a data access
    bus.d_req = 1'b1; bus.d_addr = 32'h300; memDrive(0); tick();
    chk("midrst m_req before", bus.m_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst m_req", bus.m_req, 0);
    chk("midrst d_done", bus.d_done, 0);
    chk("midrst m_addr", bus.m_addr, 0);
    chk("midrst i_rdata", bus.i_rdata, 0);
    chk("midrst d_rdata", bus.d_rdata, 0);
    setIdle();
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    // starvation: data keeps re-requesting while a fetch waits
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_addr = 32'h100;
    ifSeen = 1'b0; dGrants = 0;
    for (int c = 0; c < 60 && !ifSeen; c++) begin
      if (eDDone) bus.d_addr = 32'h100 + 32'((c % 8) * 4);
      memDrive(cur.active);
      prevReq = bus.m_req;
      tick();
      if (bus.m_req && !prevReq) begin
        if (bus.m_addr == 32'h400) ifSeen = 1'b1;
        else dGrants++;
      end
    end
    chk("starve IF granted", ifSeen, 1);
    chk("starve data grants", dGrants, SMAX);
    bus.d_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (eIDone) bus.i_req = 1'b0;
      memDrive(cur.active);
      tick();
    end

    // random traffic
    for (int seg = 0; seg < 6; seg++) begin
      pI   = $urandom_range(20, 90);
      pD   = $urandom_range(10, 95);
      pF   = $urandom_range(0, 15);
      pAck = $urandom_range(20, 100);
      for (int c = 0; c < 500; c++) begin
        bus.i_flush = 1'b0;
        if (bus.i_req) begin
          if (eIDone) begin
            if ($urandom_range(0, 99) < pI) bus.i_addr += 32'd4;
            else bus.i_req = 1'b0;
          end else if ($urandom_range(0, 99) < pF) begin
            bus.i_flush = 1'b1;
            bus.i_addr = 32'h1000 + 32'($urandom_range(0, 63) * 4);
          end
        end else if ($urandom_range(0, 99) < pI) begin
          bus.i_req = 1'b1;
          bus.i_addr = 32'h1000 + 32'($urandom_range(0, 63) * 4);
        end
        if (bus.d_req) begin
          if (eDDone) begin
            if ($urandom_range(0, 99) < pD) newData();
            else bus.d_req = 1'b0;
          end
        end else if ($urandom_range(0, 99) < pD) begin
          newData();
        end
        if (cur.active) begin
          ackWait++;
          a = (ackWait >= 4) || ($urandom_range(0, 99) < pAck);
          if (a) ackWait = 0;
        end else begin
          ackWait = 0;
          a = ($urandom_range(0, 99) < 10);
        end
        memDrive(a);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
